// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states and word geometry.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_BITS      = BYTES_PER_WORD * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Status bits carried by each state, packed as {byte_ready, busy, done, cpu_rst_n}.
    function automatic logic [3:0] status_of(state_e s);
        case (s)
            IDLE:    status_of = 4'b0001;
            RECV:    status_of = 4'b1100;
            WRITE:   status_of = 4'b0100;
            DONE:    status_of = 4'b0011;
            default: status_of = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: load control, byte stream in, memory write port and core status out.
interface imem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic                  abort;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  we;
    logic [DATA_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  cpu_rst_n;

    modport master (
        output start, len, abort, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, busy, done, err, cpu_rst_n
    );

    modport slave (
        input  start, len, abort, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, busy, done, err, cpu_rst_n
    );
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte packer: shifts bytes in from the top and flags the fourth byte.
module byte_to_word
    import imem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 byte_en_i,
    input  logic [7:0]           byte_i,
    output logic [WORD_BITS-1:0] word_o,
    output logic                 word_ready_o
);
    logic [WORD_BITS-1:0] sr_q, sr_d;
    logic [1:0]           cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (byte_en_i) begin
            sr_d  = {byte_i, sr_q[WORD_BITS-1:8]};
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Word output is the post-acceptance value so the writer can latch it with the last byte.
    assign word_o       = sr_d;
    assign word_ready_o = byte_en_i & ~clr_i & (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory while holding the core in reset.
//   state | meaning
//   IDLE  | waiting for start, core released
//   RECV  | collecting bytes of the current word
//   WRITE | one-cycle memory write of the assembled word
//   DONE  | load complete, done held until next start or abort
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  busy_q, done_q, err_q;
    logic                  byte_ready_q, cpu_rst_n_q;

    logic                  start_ok;
    logic                  byte_en;
    logic                  word_ready;
    logic [WORD_BITS-1:0]  word;

    assign start_ok = bus.start & ~bus.abort & ((state_q == IDLE) | (state_q == DONE));
    assign byte_en  = bus.byte_valid & (state_q == RECV) & ~bus.abort;

    byte_to_word u_b2w (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (bus.abort | start_ok),
        .byte_en_i    (byte_en),
        .byte_i       (bus.byte_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.len == '0)          state_d = DONE;
                        else if (bus.len > MAX_LEN) state_d = IDLE;
                        else                        state_d = RECV;
                    end
                end
                RECV:    if (word_ready) state_d = WRITE;
                WRITE:   state_d = ((word_cnt_q + 1'b1) == len_q) ? DONE : RECV;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b0;
            cpu_rst_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            {byte_ready_q, busy_q, done_q, cpu_rst_n_q} <= status_of(state_d);
            we_q    <= 1'b0;
            // Abort leaves err alone and never lets a half-built word reach memory.
            if (!bus.abort) begin
                if (start_ok) begin
                    if (bus.len == '0) begin
                        err_q <= 1'b0;
                    end else if (bus.len > MAX_LEN) begin
                        err_q <= 1'b1;
                    end else begin
                        len_q      <= bus.len;
                        word_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end else if (state_q == RECV && word_ready) begin
                    we_q    <= 1'b1;
                    waddr_q <= DATA_WIDTH'(word_cnt_q) << 2;
                    wdata_q <= DATA_WIDTH'(word);
                end else if (state_q == WRITE) begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.byte_ready = rst & byte_ready_q;
    assign bus.cpu_rst_n  = rst & cpu_rst_n_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with hand-computed write expectations.
module tb_imem_loader;
    logic clk;
    logic rst;

    imem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            we_cnt++;
            wa_q.push_back(bus.waddr);
            wd_q.push_back(bus.wdata);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   k;
        logic acc;
        k = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        do begin
            acc = bus.byte_ready;
            step(1);
            k++;
        end while (!acc && k < 50);
        if (!acc) check("byte_handshake_timeout", 32'd0, 32'd1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        logic [7:0]  prog [8];
        logic [31:0] w;
        int          base;

        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        rst = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_data = '0;

        // Reset state
        step(2);
        check("rst_we", bus.we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_cpu_rst_n", bus.cpu_rst_n, 0);
        check("rst_waddr", bus.waddr, 0);
        check("rst_wdata", bus.wdata, 0);
        rst = 1'b1;
        step(1);
        check("idle_cpu_rst_n", bus.cpu_rst_n, 1);

        // Two-word back-to-back load
        clear_log();
        do_start(9'd2);
        check("t1_busy", bus.busy, 1);
        check("t1_cpu_rst_n_low", bus.cpu_rst_n, 0);
        check("t1_byte_ready", bus.byte_ready, 1);
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        check("t1_we0", bus.we, 1);
        check("t1_waddr0", bus.waddr, 32'h0);
        check("t1_wdata0", bus.wdata, 32'h0000_0013);
        check("t1_ready_in_write", bus.byte_ready, 0);
        for (int i = 4; i < 8; i++) send_byte(prog[i]);
        check("t1_we1", bus.we, 1);
        check("t1_cpu_rst_n_write", bus.cpu_rst_n, 0);
        step(1);
        check("t1_done", bus.done, 1);
        check("t1_cpu_rst_n_done", bus.cpu_rst_n, 1);
        check("t1_busy_done", bus.busy, 0);
        check("t1_nwrites", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("t1_log_a0", wa_q[0], 32'h0);
            check("t1_log_d0", wd_q[0], 32'h0000_0013);
            check("t1_log_a1", wa_q[1], 32'h4);
            check("t1_log_d1", wd_q[1], 32'h0010_0093);
        end

        // Bytes while DONE are ignored
        bus.byte_valid = 1'b1; bus.byte_data = 8'hFF;
        step(3);
        bus.byte_valid = 1'b0;
        check("t2_done_hold", bus.done, 1);
        check("t2_no_we_in_done", wa_q.size(), 2);

        // Gapped valid, plus a start while busy that must be ignored
        clear_log();
        do_start(9'd2);
        check("t2_done_cleared", bus.done, 0);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i]);
            if (i == 1) begin
                bus.start = 1'b1; bus.len = 9'd1;
            end
            step(1);
            bus.start = 1'b0;
        end
        step(2);
        check("t2_done", bus.done, 1);
        check("t2_nwrites", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("t2_log_a0", wa_q[0], 32'h0);
            check("t2_log_d0", wd_q[0], 32'h0000_0013);
            check("t2_log_a1", wa_q[1], 32'h4);
            check("t2_log_d1", wd_q[1], 32'h0010_0093);
        end

        // len=0 and len=257
        base = we_cnt;
        do_start(9'd0);
        check("t3_len0_done", bus.done, 1);
        check("t3_len0_busy", bus.busy, 0);
        do_start(9'd257);
        check("t3_len257_err", bus.err, 1);
        check("t3_len257_done", bus.done, 0);
        check("t3_len257_busy", bus.busy, 0);
        check("t3_len257_ready", bus.byte_ready, 0);
        step(2);
        check("t3_no_we", we_cnt, base);

        // Abort with a byte offered on the same cycle, then a clean one-word load
        clear_log();
        do_start(9'd1);
        check("t4_err_cleared", bus.err, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        bus.abort = 1'b1; bus.byte_valid = 1'b1; bus.byte_data = 8'h33;
        step(1);
        bus.abort = 1'b0; bus.byte_valid = 1'b0;
        check("t4_abort_busy", bus.busy, 0);
        check("t4_abort_ready", bus.byte_ready, 0);
        check("t4_abort_done", bus.done, 0);
        step(3);
        check("t4_abort_no_we", wa_q.size(), 0);
        do_start(9'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        step(1);
        check("t4_done", bus.done, 1);
        check("t4_nwrites", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check("t4_log_a0", wa_q[0], 32'h0);
            check("t4_log_d0", wd_q[0], 32'hDDCC_BBAA);
        end

        // Full-depth load
        clear_log();
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(8'(i) ^ 8'h5A);
            send_byte(8'h00);
            send_byte(8'h80);
        end
        step(1);
        check("t5_done", bus.done, 1);
        step(2);
        check("t5_nwrites", wa_q.size(), 256);
        if (wa_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                w = {8'h80, 8'h00, 8'(i) ^ 8'h5A, 8'(i)};
                check("t5_addr", wa_q[i], 32'(i) * 32'd4);
                check("t5_data", wd_q[i], w);
            end
            check("t5_last_addr", wa_q[255], 32'h3FC);
        end

        // Reset while in WRITE
        do_start(9'd2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("t6_in_write", bus.we, 1);
        rst = 1'b0;
        step(1);
        check("t6_we", bus.we, 0);
        check("t6_waddr", bus.waddr, 0);
        check("t6_wdata", bus.wdata, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_done", bus.done, 0);
        check("t6_err", bus.err, 0);
        check("t6_ready", bus.byte_ready, 0);
        check("t6_cpu_rst_n", bus.cpu_rst_n, 0);
        base = we_cnt;
        bus.byte_valid = 1'b1; bus.byte_data = 8'h55;
        step(3);
        rst = 1'b1;
        step(8);
        bus.byte_valid = 1'b0;
        check("t6_no_more_we", we_cnt, base);
        check("t6_idle_ready", bus.byte_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the instruction memory depth as 2^ADDR_WIDTH words.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  as its reset: synchronous and active-low.
REQ-005 The block SHALL have port start  input  1  as the load-request pulse.
REQ-006 The block SHALL have port len  input  ADDR_WIDTH+1  as the word count to load, sampled with start.
REQ-007 The block SHALL have port abort  input  1  to cancel a load in progress.
REQ-008 The block SHALL have port byte_valid  input  1  to mark byte_data as valid.
REQ-009 The block SHALL have port byte_data  input  8  as the program byte stream.
REQ-010 The block SHALL have port byte_ready  output  1  signalling it can accept a byte.
REQ-011 The block SHALL have port we  output  1  as the instruction memory write enable.
REQ-012 The block SHALL have port waddr  output  DATA_WIDTH  as the byte address of the write, word-aligned.
REQ-013 The block SHALL have port wdata  output  DATA_WIDTH  as the write data.
REQ-014 The block SHALL have port busy, done, err  output  1 each  as status.
REQ-015 The block SHALL have port cpu_rst_n  output  1  as the hold-in-reset for the core (PC and fetch).

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-017 IDLE/DONE on start=1, abort=0: len=0 -> DONE next cycle; len>2^ADDR_WIDTH -> err=1, go to IDLE; otherwise latch len, word_cnt=0, byte_cnt=0, err=0, done=0, go to RECV.
REQ-018 byte_ready SHALL be 1 only in RECV; a byte is accepted only when byte_valid & byte_ready.
REQ-019 Bytes SHALL be packed little-endian: the first accepted byte goes to wdata[7:0] and the fourth to wdata[31:24].
REQ-020 On acceptance of the 4th byte (byte_cnt=3), the next cycle SHALL be WRITE.
REQ-021 In WRITE, we=1 for exactly one cycle, with waddr = word_cnt*4 and wdata the assembled word; word_cnt then increments.
REQ-022 After WRITE the FSM SHALL go to DONE if the incremented word_cnt equals len, otherwise back to RECV with byte_cnt=0.
REQ-023 busy SHALL be 1 in RECV and WRITE; done SHALL be 1 in DONE and held until the next accepted start or abort.
REQ-024 cpu_rst_n SHALL be 0 in RECV and WRITE and 1 in IDLE and DONE.
REQ-025 start while busy SHALL be ignored, and byte_valid outside RECV SHALL be ignored.
REQ-026 abort in any state SHALL go to IDLE next cycle, discarding any partial word; no we is issued; done=0; err unchanged. abort has priority over start and over a same-cycle byte.
REQ-027 word_cnt SHALL never exceed len, so waddr never wraps past word 2^ADDR_WIDTH-1.

Reset
REQ-028 With rst=0 at a clock edge, the FSM SHALL enter IDLE and byte_cnt, word_cnt, we, waddr, wdata, busy, done and err SHALL all go to 0.
REQ-029 While rst=0, byte_ready SHALL be 0 and cpu_rst_n SHALL be 0.
REQ-030 Reset mid-load SHALL drop the load with no further writes.

Structure
REQ-031 The shared package SHALL hold the FSM state enum and BYTES_PER_WORD=4.
REQ-032 Byte assembly SHALL be a sub-module byte_to_word: a shift register plus 2-bit counter, outputting the word and a word_ready flag.

Verification
REQ-033 The bench SHALL check: start, len=2, bytes 13 00 00 00 93 00 10 00 -> we pulses at waddr 0x0 with wdata 0x00000013 and at waddr 0x4 with wdata 0x00100093; done=1; cpu_rst_n rises on entry to DONE.
REQ-034 The bench SHALL check: byte_valid toggling 1/0 during RECV -> only handshaked bytes are packed, and wdata is unchanged versus the back-to-back case.
REQ-035 The bench SHALL check: len=0 -> DONE one cycle after start with no we; len=257 (ADDR_WIDTH=8) -> err=1, IDLE, no we.
REQ-036 The bench SHALL check: abort after 2 bytes of word 1 -> IDLE, no we; a following load with len=1 writes at waddr 0x0.
REQ-037 The bench SHALL check: len=256 full-depth load -> last we at waddr 0x3FC, then DONE, with no write to 0x400.
REQ-038 The bench SHALL check: rst=0 asserted during WRITE -> all outputs 0 next cycle, and we stays 0 thereafter.
